vc_link_tx: RTL and testbench

// - Output-side counterpart of the VC allocator: drains the two per-port VC FIFOs (VC0, VC1) onto one
//   32-bit output link towards the next router.
// - Wormhole, packet-locked: once a VC's header wins, that VC owns the link until its tail.
// - Round-robin between VCs at packet boundaries.
// - Credit-based flow control per downstream VC buffer.

---
 rtl/noc_pkg.sv | 25 ++
 rtl/vc_credit_counter.sv | 32 +++
 rtl/vc_link_tx.sv | 167 ++++++++++++++++
 tb/tb_vc_link_tx.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC link definitions: flit field layout, flit type codes, output-link FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package noc_pkg;

    localparam int FLIT_W = 32;
    localparam int ADDR_W = 4;

    localparam int TYPE_MSB = 31;
    localparam int TYPE_LSB = 30;
    localparam int SRC_MSB  = 29;
    localparam int SRC_LSB  = 26;

    localparam logic [1:0] TYPE_HEAD = 2'b10;
    localparam logic [1:0] TYPE_BODY = 2'b00;
    localparam logic [1:0] TYPE_TAIL = 2'b01;
    localparam logic [1:0] TYPE_HT   = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND_VC0 = 2'd1,
        SEND_VC1 = 2'd2
    } tx_state_t;

endpackage

// File: rtl/vc_credit_counter.sv
// Credit counter for one downstream VC buffer, preset to BUF_DEPTH on reset.
// Latency: count updates on the edge after dec/inc; nonzero/overflow are combinational.
// Backpressure: nonzero gates sends; inc at full credit saturates and flags overflow.
module vc_credit_counter #(
    parameter int BUF_DEPTH = 4,
    parameter int CW        = $clog2(BUF_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dec,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          nonzero,
    output logic          overflow
);

    localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= FULL;
        end else if (dec && !inc) begin
            count <= count - 1'b1;
        end else if (inc && !dec && count != FULL) begin
            count <= count + 1'b1;
        end
    end

    assign nonzero  = (count != '0);
    assign overflow = inc && !dec && (count == FULL);

endmodule

// File: rtl/vc_link_tx.sv
// Drains two VC FIFOs onto one output link: wormhole packet lock, round-robin at packet boundaries.
// Latency: a flit popped in cycle N is on data_flit_out with valid_out=1 after edge N+1.
// Backpressure: a VC is served only while its FIFO is non-empty and it holds a downstream credit.
module vc_link_tx
    import noc_pkg::*;
#(
    parameter int bit_of_flit    = FLIT_W,
    parameter int bit_of_address = ADDR_W,
    parameter int BUF_DEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [bit_of_flit-1:0] data_flit_VC0,
    input  logic [bit_of_flit-1:0] data_flit_VC1,
    input  logic                   empty0,
    input  logic                   empty1,
    output logic                   rd_en0,
    output logic                   rd_en1,
    input  logic                   credit_in0,
    input  logic                   credit_in1,
    output logic [bit_of_flit-1:0] data_flit_out,
    output logic                   valid_out,
    output logic                   vc_out,
    output logic                   error
);

    localparam int CW = $clog2(BUF_DEPTH + 1);

    if (bit_of_flit != FLIT_W || bit_of_address != ADDR_W ||
        SRC_MSB - SRC_LSB + 1 != bit_of_address || BUF_DEPTH < 1 || BUF_DEPTH > 15) begin : g_bad_param
        $error("vc_link_tx: unsupported parameterisation");
    end

    tx_state_t              state, state_nxt;
    logic                   last_grant, last_grant_nxt;
    logic                   send, send_vc, proto_err;
    logic [bit_of_flit-1:0] send_flit;

    logic [CW-1:0] credit0, credit1;
    logic          credit_nz0, credit_nz1;
    logic          credit_ov0, credit_ov1;

    logic [1:0] type0, type1;
    logic       elig0, elig1;
    logic       orphan0, orphan1;
    logic       head0, head1;

    assign type0 = data_flit_VC0[TYPE_MSB:TYPE_LSB];
    assign type1 = data_flit_VC1[TYPE_MSB:TYPE_LSB];

    // Credit is the registered value: a same-cycle credit_in cannot unblock a VC at zero.
    assign elig0 = !empty0 && credit_nz0;
    assign elig1 = !empty1 && credit_nz1;

    assign orphan0 = elig0 && (type0 == TYPE_BODY || type0 == TYPE_TAIL);
    assign orphan1 = elig1 && (type1 == TYPE_BODY || type1 == TYPE_TAIL);
    assign head0   = elig0 && (type0 == TYPE_HEAD || type0 == TYPE_HT);
    assign head1   = elig1 && (type1 == TYPE_HEAD || type1 == TYPE_HT);

    always_comb begin
        rd_en0         = 1'b0;
        rd_en1         = 1'b0;
        send           = 1'b0;
        send_vc        = 1'b0;
        send_flit      = data_flit_VC0;
        state_nxt      = state;
        last_grant_nxt = last_grant;
        proto_err      = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    // Stray body/tail flits are flushed first; arbitration waits a cycle.
                    if (orphan0 || orphan1) begin
                        rd_en0    = orphan0;
                        rd_en1    = orphan1;
                        proto_err = 1'b1;
                    end else if (head0 && (!head1 || last_grant)) begin
                        rd_en0         = 1'b1;
                        send           = 1'b1;
                        send_vc        = 1'b0;
                        send_flit      = data_flit_VC0;
                        last_grant_nxt = 1'b0;
                        if (type0 == TYPE_HEAD) state_nxt = SEND_VC0;
                    end else if (head1) begin
                        rd_en1         = 1'b1;
                        send           = 1'b1;
                        send_vc        = 1'b1;
                        send_flit      = data_flit_VC1;
                        last_grant_nxt = 1'b1;
                        if (type1 == TYPE_HEAD) state_nxt = SEND_VC1;
                    end
                end
                SEND_VC0: begin
                    if (elig0) begin
                        rd_en0    = 1'b1;
                        send      = 1'b1;
                        send_vc   = 1'b0;
                        send_flit = data_flit_VC0;
                        if (type0 == TYPE_TAIL) begin
                            state_nxt = IDLE;
                        end else if (type0 == TYPE_HEAD || type0 == TYPE_HT) begin
                            proto_err = 1'b1;
                        end
                    end
                end
                SEND_VC1: begin
                    if (elig1) begin
                        rd_en1    = 1'b1;
                        send      = 1'b1;
                        send_vc   = 1'b1;
                        send_flit = data_flit_VC1;
                        if (type1 == TYPE_TAIL) begin
                            state_nxt = IDLE;
                        end else if (type1 == TYPE_HEAD || type1 == TYPE_HT) begin
                            proto_err = 1'b1;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            data_flit_out <= '0;
            valid_out     <= 1'b0;
            vc_out        <= 1'b0;
            error         <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            valid_out  <= send;
            if (send) begin
                data_flit_out <= send_flit;
                vc_out        <= send_vc;
            end
            if (proto_err || credit_ov0 || credit_ov1) error <= 1'b1;
        end
    end

    vc_credit_counter #(.BUF_DEPTH(BUF_DEPTH), .CW(CW)) u_credit0 (
        .clk      (clk),
        .rst      (rst),
        .dec      (send && !send_vc),
        .inc      (credit_in0),
        .count    (credit0),
        .nonzero  (credit_nz0),
        .overflow (credit_ov0)
    );

    vc_credit_counter #(.BUF_DEPTH(BUF_DEPTH), .CW(CW)) u_credit1 (
        .clk      (clk),
        .rst      (rst),
        .dec      (send && send_vc),
        .inc      (credit_in1),
        .count    (credit1),
        .nonzero  (credit_nz1),
        .overflow (credit_ov1)
    );

    a_credit0_range: assert property (@(posedge clk) disable iff (rst) credit0 <= CW'(BUF_DEPTH));
    a_credit1_range: assert property (@(posedge clk) disable iff (rst) credit1 <= CW'(BUF_DEPTH));

endmodule

// File: tb/tb_vc_link_tx.sv
// Bench for vc_link_tx: two instances (credit depth 4 and 2) fed from queue-modelled FIFOs,
// a packet-level reference model compared every cycle, plus literal expectations per scenario.
module tb_vc_link_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [31:0] head [4];
    logic [3:0]  emp = 4'hF;
    logic [3:0]  cin = 4'h0;
    logic [3:0]  rd;
    logic [31:0] dout [2];
    logic [1:0]  vld, vco, err;

    int total = 0;
    int bad   = 0;

    logic [31:0] fq [4][$];
    logic [32:0] lg [2][$];

    // Reference model state, per instance d; lock = -1 means no VC owns the link.
    int          depth [2] = '{4, 2};
    int          lock  [2] = '{-1, -1};
    int          last  [2] = '{1, 1};
    int          cred  [2][2] = '{'{4, 4}, '{2, 2}};
    bit          merr  [2] = '{0, 0};
    bit          mvld  [2] = '{0, 0};
    bit          mvc   [2] = '{0, 0};
    logic [31:0] mdat  [2] = '{32'h0, 32'h0};
    bit          pop   [4] = '{0, 0, 0, 0};

    vc_link_tx #(.bit_of_flit(32), .bit_of_address(4), .BUF_DEPTH(4)) u_a (
        .clk(clk), .rst(rst),
        .data_flit_VC0(head[0]), .data_flit_VC1(head[1]),
        .empty0(emp[0]), .empty1(emp[1]),
        .rd_en0(rd[0]), .rd_en1(rd[1]),
        .credit_in0(cin[0]), .credit_in1(cin[1]),
        .data_flit_out(dout[0]), .valid_out(vld[0]), .vc_out(vco[0]), .error(err[0])
    );

    vc_link_tx #(.bit_of_flit(32), .bit_of_address(4), .BUF_DEPTH(2)) u_b (
        .clk(clk), .rst(rst),
        .data_flit_VC0(head[2]), .data_flit_VC1(head[3]),
        .empty0(emp[2]), .empty1(emp[3]),
        .rd_en0(rd[2]), .rd_en1(rd[3]),
        .credit_in0(cin[2]), .credit_in1(cin[3]),
        .data_flit_out(dout[1]), .valid_out(vld[1]), .vc_out(vco[1]), .error(err[1])
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic model_step(input int d);
        bit          el [2];
        logic [1:0]  ty [2];
        bit          pp [2];
        bit          orph, c0, c1;
        int          sv;
        chk($sformatf("d%0d valid_out", d), 64'(vld[d]), 64'(mvld[d]));
        chk($sformatf("d%0d data_out", d), 64'(dout[d]), 64'(mdat[d]));
        if (mvld[d]) chk($sformatf("d%0d vc_out", d), 64'(vco[d]), 64'(mvc[d]));
        chk($sformatf("d%0d error", d), 64'(err[d]), 64'(merr[d]));
        pp = '{0, 0};
        sv = -1;
        for (int v = 0; v < 2; v++) begin
            el[v] = !emp[d*2+v] && cred[d][v] > 0;
            ty[v] = head[d*2+v][31:30];
        end
        if (!rst) begin
            if (lock[d] < 0) begin
                orph = 1'b0;
                for (int v = 0; v < 2; v++) begin
                    if (el[v] && !ty[v][1]) begin
                        pp[v] = 1'b1;
                        orph  = 1'b1;
                    end
                end
                if (orph) begin
                    merr[d] = 1'b1;
                end else begin
                    c0 = el[0] && ty[0][1];
                    c1 = el[1] && ty[1][1];
                    if (c0 && c1) sv = (last[d] == 0) ? 1 : 0;
                    else if (c0)  sv = 0;
                    else if (c1)  sv = 1;
                    if (sv >= 0) begin
                        last[d] = sv;
                        if (ty[sv] == 2'b10) lock[d] = sv;
                    end
                end
            end else if (el[lock[d]]) begin
                sv = lock[d];
                if (ty[sv] == 2'b01) lock[d] = -1;
                else if (ty[sv][1]) merr[d] = 1'b1;
            end
            if (sv >= 0) pp[sv] = 1'b1;
        end
        chk($sformatf("d%0d rd_en0", d), 64'(rd[d*2]), 64'(pp[0]));
        chk($sformatf("d%0d rd_en1", d), 64'(rd[d*2+1]), 64'(pp[1]));
        if (rst) begin
            lock[d] = -1; last[d] = 1; merr[d] = 0; mvld[d] = 0; mvc[d] = 0; mdat[d] = '0;
            cred[d][0] = depth[d];
            cred[d][1] = depth[d];
        end else begin
            for (int v = 0; v < 2; v++) begin
                if (sv == v && !cin[d*2+v]) cred[d][v]--;
                else if (cin[d*2+v] && sv != v) begin
                    if (cred[d][v] == depth[d]) merr[d] = 1'b1;
                    else cred[d][v]++;
                end
            end
            mvld[d] = (sv >= 0);
            if (sv >= 0) begin
                mdat[d] = head[d*2+sv];
                mvc[d]  = sv[0];
            end
        end
        pop[d*2]   = pp[0];
        pop[d*2+1] = pp[1];
    endtask

    // Per-cycle compare, FIFO pops and FIFO head presentation.
    initial begin
        for (int k = 0; k < 4; k++) head[k] = '0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (vld[d]) lg[d].push_back({vco[d], dout[d]});
                model_step(d);
            end
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++)
                if (pop[k] && fq[k].size() > 0) void'(fq[k].pop_front());
            #1;
            for (int k = 0; k < 4; k++) begin
                emp[k]  = (fq[k].size() == 0);
                head[k] = (fq[k].size() > 0) ? fq[k][0] : 32'h0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int d, input int v, input logic [31:0] f);
        fq[d*2+v].push_back(f);
    endtask

    task automatic cpulse(input int d, input int v);
        cin[d*2+v] = 1'b1;
        tick(1);
        cin[d*2+v] = 1'b0;
    endtask

    task automatic chk_log(input string nm, input int d, input int idx, input logic [32:0] exp);
        logic [32:0] act;
        act = (idx < lg[d].size()) ? lg[d][idx] : 33'h0;
        chk(nm, 64'(act), 64'(exp));
    endtask

    initial begin
        tick(2);
        chk("reset valid_out", 64'(vld[0]), 64'd0);
        chk("reset data_out", 64'(dout[0]), 64'd0);
        chk("reset error", 64'(err[0]), 64'd0);
        rst = 1'b0;
        tick(1);

        // Credit stall on depth-2 instance.
        push(1, 1, 32'h8C00_0041); push(1, 1, 32'h0C00_0042); push(1, 1, 32'h4C00_0043);
        tick(8);
        chk("stall flits sent", 64'(lg[1].size()), 64'd2);
        chk_log("stall hdr", 1, 0, {1'b1, 32'h8C00_0041});
        chk_log("stall body", 1, 1, {1'b1, 32'h0C00_0042});
        chk("stall valid_out", 64'(vld[1]), 64'd0);
        cpulse(1, 1);
        tick(4);
        chk_log("stall tail", 1, 2, {1'b1, 32'h4C00_0043});
        cpulse(1, 1); tick(1); cpulse(1, 1); tick(1);
        push(1, 0, 32'hC800_0050);
        tick(4);
        chk_log("stall back to idle", 1, 3, {1'b0, 32'hC800_0050});
        chk("stall error", 64'(err[1]), 64'd0);

        // Single packet on VC0, then only one credit left.
        push(0, 0, 32'h8400_0001); push(0, 0, 32'h0400_0002); push(0, 0, 32'h4400_0003);
        tick(6);
        chk_log("pkt hdr", 0, 0, {1'b0, 32'h8400_0001});
        chk_log("pkt body", 0, 1, {1'b0, 32'h0400_0002});
        chk_log("pkt tail", 0, 2, {1'b0, 32'h4400_0003});
        push(0, 0, 32'hC400_0010); push(0, 0, 32'hC400_0011);
        tick(4);
        chk("one credit left", 64'(lg[0].size()), 64'd4);
        for (int i = 0; i < 5; i++) begin
            cpulse(0, 0);
            tick(1);
        end
        chk_log("after credit return", 0, 4, {1'b0, 32'hC400_0011});
        chk("pkt error", 64'(err[0]), 64'd0);

        // Both VCs hold a header right after reset: VC0 packet first, no interleave.
        rst = 1'b1; tick(1); rst = 1'b0;
        lg[0].delete();
        push(0, 0, 32'h8800_0001); push(0, 0, 32'h0800_0002); push(0, 0, 32'h4800_0003);
        push(0, 1, 32'h8C00_0011); push(0, 1, 32'h0C00_0012); push(0, 1, 32'h4C00_0013);
        tick(10);
        chk_log("rr 0", 0, 0, {1'b0, 32'h8800_0001});
        chk_log("rr 2", 0, 2, {1'b0, 32'h4800_0003});
        chk_log("rr 3", 0, 3, {1'b1, 32'h8C00_0011});
        chk_log("rr 5", 0, 5, {1'b1, 32'h4C00_0013});
        for (int i = 0; i < 3; i++) begin
            cin[0] = 1'b1; cin[1] = 1'b1;
            tick(1);
            cin[0] = 1'b0; cin[1] = 1'b0;
            tick(1);
        end

        // Single-flit packet on VC0 against a VC1 header.
        lg[0].delete();
        push(0, 0, 32'hC400_0000); push(0, 1, 32'h8C00_0021); push(0, 1, 32'h4C00_0022);
        tick(6);
        chk_log("ht first", 0, 0, {1'b0, 32'hC400_0000});
        chk_log("ht then vc1", 0, 1, {1'b1, 32'h8C00_0021});
        chk_log("ht vc1 tail", 0, 2, {1'b1, 32'h4C00_0022});
        cpulse(0, 0); tick(1); cpulse(0, 1); tick(1); cpulse(0, 1); tick(1);
        chk("ht error", 64'(err[0]), 64'd0);

        // Orphan body on VC1 while idle.
        lg[0].delete();
        push(0, 1, 32'h0800_0005);
        #3;
        chk("orphan rd_en1", 64'(rd[1]), 64'd1);
        tick(3);
        chk("orphan error", 64'(err[0]), 64'd1);
        chk("orphan not sent", 64'(lg[0].size()), 64'd0);
        tick(5);
        chk("orphan error sticky", 64'(err[0]), 64'd1);

        // Reset mid-packet on VC0.
        push(0, 0, 32'h8400_0031); push(0, 0, 32'h0400_0032);
        push(0, 0, 32'h0400_0033); push(0, 0, 32'h4400_0034);
        tick(3);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) fq[k].delete();
        tick(1);
        rst = 1'b0;
        chk("midrst valid_out", 64'(vld[0]), 64'd0);
        chk("midrst error", 64'(err[0]), 64'd0);
        tick(1);
        chk("midrst idle", 64'(vld[0]), 64'd0);
        cpulse(0, 0);
        chk("credit overflow error", 64'(err[0]), 64'd1);

        tick(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
